// File: rtl/jk_seq_pkg.sv
// Shared types and helpers for the JK flop bank sequencer.
package jk_seq_pkg;

    // Widest flop index the command format can carry (a bank holds at most 32 flops).
    localparam int IDX_MAX_W = 5;

    typedef enum logic [1:0] {
        OP_HOLD   = 2'b00,
        OP_RESET  = 2'b01,
        OP_SET    = 2'b10,
        OP_TOGGLE = 2'b11
    } jk_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic [IDX_MAX_W-1:0] idx;
        jk_op_e               op;
        logic [2:0]           rep;
    } jk_cmd_t;

    localparam int CMD_W = $bits(jk_cmd_t);

    // Value a healthy JK flop must show after one edge with the given command applied.
    function automatic logic expected_q(input jk_op_e op, input logic prev);
        case (op)
            OP_HOLD:  return prev;
            OP_RESET: return 1'b0;
            OP_SET:   return 1'b1;
            default:  return ~prev;
        endcase
    endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Small synchronous command FIFO; head entry is visible combinationally so the
// sequencer can pop and start driving in the same cycle.
module jk_cmd_fifo
    import jk_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [CMD_W-1:0] wdata,
    input  logic             pop,
    output logic [CMD_W-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [CMD_W-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    // Extra MSB on each pointer distinguishes full from empty when the low bits match.
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign rdata     = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; reset flushes the queue.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/jk_bank_sequencer.sv
// Command-driven exerciser for a bank of JK flops: drives one flop per command
// step, then checks its output on the following cycle and latches errors.
module jk_bank_sequencer
    import jk_seq_pkg::*;
#(
    parameter int N_FF       = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int IDX_W      = $clog2(N_FF)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [IDX_W-1:0] cmd_idx,
    input  logic [1:0]       cmd_op,
    input  logic [2:0]       cmd_rep,
    output logic [N_FF-1:0]  j_vec,
    output logic [N_FF-1:0]  k_vec,
    input  logic [N_FF-1:0]  ff_q,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [IDX_W-1:0] err_idx,
    input  logic             err_clr
);

    localparam logic [IDX_MAX_W:0] NFF_L = (IDX_MAX_W+1)'(N_FF);

    seq_state_e        r_state;
    logic [IDX_W-1:0]  r_cur_idx;
    jk_op_e            r_cur_op;
    logic [2:0]        r_rep_left;
    logic              r_oor;
    logic              r_prev;
    logic [N_FF-1:0]   r_j_vec;
    logic [N_FF-1:0]   r_k_vec;
    logic              r_done;
    logic              r_err;
    logic [IDX_W-1:0]  r_err_idx;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    jk_cmd_t           w_wcmd;
    jk_cmd_t           w_head;
    logic [CMD_W-1:0]  w_wdata;
    logic [CMD_W-1:0]  w_rdata;
    logic              w_head_oor;
    logic              w_rep_again;
    logic [IDX_W-1:0]  w_drv_idx;
    jk_op_e            w_drv_op;
    logic              w_drv_oor;
    logic [N_FF-1:0]   w_sel;
    logic [N_FF-1:0]   w_j_next;
    logic [N_FF-1:0]   w_k_next;
    logic              w_chk_err;

    assign cmd_ready = !w_full;
    assign w_push    = cmd_valid && !w_full;

    assign w_wcmd.idx = IDX_MAX_W'(cmd_idx);
    assign w_wcmd.op  = jk_op_e'(cmd_op);
    assign w_wcmd.rep = cmd_rep;
    assign w_wdata    = w_wcmd;
    assign w_head     = jk_cmd_t'(w_rdata);

    jk_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .srst  (reset),
        .push  (w_push),
        .wdata (w_wdata),
        .pop   (w_pop),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty)
    );

    // Out-of-range targets are consumed without touching the bank.
    assign w_head_oor  = ({1'b0, w_head.idx} >= NFF_L);
    assign w_rep_again = (r_state == CHECK) && !r_oor && (r_rep_left != 3'd0);
    assign w_pop       = !w_empty &&
                         ((r_state == IDLE) || ((r_state == CHECK) && !w_rep_again));

    // The next DRIVE targets either a freshly popped command or a repeat of the current one.
    assign w_drv_idx = w_pop ? IDX_W'(w_head.idx) : r_cur_idx;
    assign w_drv_op  = w_pop ? w_head.op : r_cur_op;
    assign w_drv_oor = w_pop ? w_head_oor : r_oor;

    // One-hot select of the flop about to be driven.
    generate
        for (genvar gi = 0; gi < N_FF; gi++) begin : g_sel
            assign w_sel[gi] = (w_drv_idx == IDX_W'(gi)) && !w_drv_oor;
        end
    endgenerate

    // op[1] maps to J and op[0] to K, so hold leaves both lines low.
    assign w_j_next = w_sel & {N_FF{w_drv_op[1]}};
    assign w_k_next = w_sel & {N_FF{w_drv_op[0]}};

    assign w_chk_err = (r_state == CHECK) &&
                       (r_oor || (ff_q[r_cur_idx] != expected_q(r_cur_op, r_prev)));

    // Sequencer FSM with registered j/k/done outputs and sticky error status.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cur_idx  <= '0;
            r_cur_op   <= OP_HOLD;
            r_rep_left <= '0;
            r_oor      <= 1'b0;
            r_prev     <= 1'b0;
            r_j_vec    <= '0;
            r_k_vec    <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_idx  <= '0;
        end else begin
            r_j_vec <= '0;
            r_k_vec <= '0;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_cur_idx  <= IDX_W'(w_head.idx);
                        r_cur_op   <= w_head.op;
                        r_rep_left <= w_head.rep;
                        r_oor      <= w_head_oor;
                        r_j_vec    <= w_j_next;
                        r_k_vec    <= w_k_next;
                        r_state    <= DRIVE;
                    end
                end
                DRIVE: begin
                    // Flop output still shows its pre-edge value here.
                    r_prev  <= r_oor ? 1'b0 : ff_q[r_cur_idx];
                    r_done  <= r_oor || (r_rep_left == 3'd0);
                    r_state <= CHECK;
                end
                CHECK: begin
                    if (w_rep_again) begin
                        r_rep_left <= r_rep_left - 3'd1;
                        r_j_vec    <= w_j_next;
                        r_k_vec    <= w_k_next;
                        r_state    <= DRIVE;
                    end else if (w_pop) begin
                        r_cur_idx  <= IDX_W'(w_head.idx);
                        r_cur_op   <= w_head.op;
                        r_rep_left <= w_head.rep;
                        r_oor      <= w_head_oor;
                        r_j_vec    <= w_j_next;
                        r_k_vec    <= w_k_next;
                        r_state    <= DRIVE;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // A new error outranks a simultaneous clear.
            if (w_chk_err) begin
                r_err     <= 1'b1;
                r_err_idx <= r_cur_idx;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign j_vec   = r_j_vec;
    assign k_vec   = r_k_vec;
    assign done    = r_done;
    assign err     = r_err;
    assign err_idx = r_err_idx;
    assign busy    = (r_state != IDLE) || !w_empty;

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Directed bench for jk_bank_sequencer with a behavioural JK bank model.
module tb_jk_bank_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_idx;
    logic [1:0] cmd_op;
    logic [2:0] cmd_rep;
    logic [7:0] j_vec, k_vec;
    logic [7:0] bank_q;
    logic       busy, done, err, err_clr;
    logic [2:0] err_idx;
    logic       bank_rst;
    logic [7:0] stuck;

    // Second instance with a non power-of-two bank for out-of-range indices.
    logic       c2_valid, c2_ready, c2_busy, c2_done, c2_err;
    logic [2:0] c2_idx, c2_err_idx;
    logic [1:0] c2_op;
    logic [2:0] c2_rep;
    logic [5:0] c2_j, c2_k, c2_q;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int act2_cnt = 0;
    int done2_cnt = 0;
    logic [15:0] drive_log[$];

    always #5 clk = ~clk;

    jk_bank_sequencer #(.N_FF(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_idx(cmd_idx), .cmd_op(cmd_op), .cmd_rep(cmd_rep),
        .j_vec(j_vec), .k_vec(k_vec), .ff_q(bank_q), .busy(busy), .done(done),
        .err(err), .err_idx(err_idx), .err_clr(err_clr)
    );

    jk_bank_sequencer #(.N_FF(6), .FIFO_DEPTH(4)) dut6 (
        .clk(clk), .reset(reset), .cmd_valid(c2_valid), .cmd_ready(c2_ready),
        .cmd_idx(c2_idx), .cmd_op(c2_op), .cmd_rep(c2_rep),
        .j_vec(c2_j), .k_vec(c2_k), .ff_q(c2_q), .busy(c2_busy), .done(c2_done),
        .err(c2_err), .err_idx(c2_err_idx), .err_clr(1'b0)
    );

    assign c2_q = 6'b0;

    // JK bank model; stuck bits never leave 0.
    always @(posedge clk) begin
        if (bank_rst) bank_q <= '0;
        else begin
            for (int i = 0; i < 8; i++) begin
                case ({j_vec[i], k_vec[i]})
                    2'b10:   bank_q[i] <= 1'b1;
                    2'b01:   bank_q[i] <= 1'b0;
                    2'b11:   bank_q[i] <= ~bank_q[i];
                    default: ;
                endcase
                if (stuck[i]) bank_q[i] <= 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (done)    done_cnt++;
        if (c2_done) done2_cnt++;
    end

    always @(negedge clk) begin
        if ((j_vec | k_vec) != 8'h00) drive_log.push_back({j_vec, k_vec});
        if ((c2_j | c2_k) != 6'h00) act2_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic [2:0] idx, input logic [1:0] op, input logic [2:0] rep);
        int w = 0;
        cmd_valid = 1'b1; cmd_idx = idx; cmd_op = op; cmd_rep = rep;
        while (!cmd_ready && w < 100) begin @(negedge clk); w++; end
        if (!cmd_ready) check_eq("push_timeout", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        $display("push idx=%0d op=%0d rep=%0d t=%0t", idx, op, rep, $time);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int w = 0;
        while (busy && w < 300) begin @(negedge clk); w++; end
        if (busy) check_eq("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int c0, w;
        logic [15:0] exp_log[$];
        reset = 1'b1; bank_rst = 1'b1; cmd_valid = 1'b0; cmd_idx = '0; cmd_op = '0;
        cmd_rep = '0; err_clr = 1'b0; stuck = '0;
        c2_valid = 1'b0; c2_idx = '0; c2_op = '0; c2_rep = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; bank_rst = 1'b0;
        check_eq("rst_ready", 32'(cmd_ready), 1);
        check_eq("rst_busy",  32'(busy), 0);
        check_eq("rst_done",  32'(done), 0);
        check_eq("rst_jk",    {16'h0, j_vec, k_vec}, 0);
        check_eq("rst_err",   32'(err), 0);
        check_eq("rst_erridx", 32'(err_idx), 0);

        // Set flop 3
        push(3'd3, 2'b10, 3'd0);
        check_eq("set_busy", 32'(busy), 1);
        check_eq("set_idle_jk", {16'h0, j_vec, k_vec}, 0);
        @(negedge clk);
        check_eq("set_drive_jk", {16'h0, j_vec, k_vec}, 32'h0800);
        @(negedge clk);
        check_eq("set_q3", 32'(bank_q[3]), 1);
        check_eq("set_done", 32'(done), 1);
        @(negedge clk);
        check_eq("set_err", 32'(err), 0);
        check_eq("set_busy_end", 32'(busy), 0);

        // Toggle flop 0 three times
        push(3'd0, 2'b11, 3'd2);
        @(negedge clk);
        for (int r = 0; r < 3; r++) begin
            check_eq($sformatf("tog_jk%0d", r), {16'h0, j_vec, k_vec}, 32'h0101);
            check_eq($sformatf("tog_ddone%0d", r), 32'(done), 0);
            @(negedge clk);
            check_eq($sformatf("tog_q%0d", r), 32'(bank_q[0]), (r == 1) ? 0 : 1);
            check_eq($sformatf("tog_done%0d", r), 32'(done), (r == 2) ? 1 : 0);
            @(negedge clk);
        end
        check_eq("tog_err", 32'(err), 0);

        // Backpressure: long command then five more
        drive_log.delete();
        push(3'd1, 2'b10, 3'd7);
        push(3'd2, 2'b10, 3'd0);
        push(3'd2, 2'b01, 3'd0);
        push(3'd4, 2'b11, 3'd0);
        push(3'd6, 2'b10, 3'd0);
        check_eq("bp_full_ready", 32'(cmd_ready), 0);
        c0 = done_cnt;
        w = 0;
        while (!cmd_ready && w < 100) begin @(negedge clk); w++; end
        check_eq("bp_ready_after_pop", 32'(done_cnt - c0), 1);
        push(3'd2, 2'b11, 3'd0);
        wait_idle();
        exp_log = '{16'h0200, 16'h0200, 16'h0200, 16'h0200, 16'h0200, 16'h0200,
                    16'h0200, 16'h0200, 16'h0400, 16'h0004, 16'h1010, 16'h4000, 16'h0404};
        check_eq("bp_log_len", drive_log.size(), 13);
        for (int i = 0; i < 13; i++)
            if (i < drive_log.size())
                check_eq($sformatf("bp_log%0d", i), 32'(drive_log[i]), 32'(exp_log[i]));
        check_eq("bp_err", 32'(err), 0);

        // Stuck flop 5
        stuck[5] = 1'b1;
        push(3'd5, 2'b10, 3'd0);
        wait_idle();
        check_eq("stk_err", 32'(err), 1);
        check_eq("stk_erridx", 32'(err_idx), 5);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_eq("stk_clr", 32'(err), 0);
        push(3'd5, 2'b10, 3'd0);
        @(negedge clk);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_eq("stk_clr_vs_set", 32'(err), 1);
        check_eq("stk_erridx2", 32'(err_idx), 5);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        stuck = '0;

        // Out-of-range on the 6-flop instance
        act2_cnt = 0; c0 = done2_cnt;
        c2_valid = 1'b1; c2_idx = 3'd7; c2_op = 2'b10; c2_rep = 3'd3;
        @(posedge clk);
        $display("push6 idx=7 op=2 rep=3 t=%0t", $time);
        @(negedge clk);
        c2_valid = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("oor_activity", act2_cnt, 0);
        check_eq("oor_done", done2_cnt - c0, 1);
        check_eq("oor_err", 32'(c2_err), 1);
        check_eq("oor_erridx", 32'(c2_err_idx), 7);
        check_eq("oor_busy", 32'(c2_busy), 0);

        // Reset during DRIVE with three queued
        push(3'd1, 2'b10, 3'd3);
        push(3'd2, 2'b10, 3'd3);
        push(3'd3, 2'b10, 3'd3);
        push(3'd4, 2'b10, 3'd3);
        check_eq("rmo_in_drive", 32'(j_vec), 32'h02);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("rmo_jk", {16'h0, j_vec, k_vec}, 0);
        check_eq("rmo_busy", 32'(busy), 0);
        check_eq("rmo_ready", 32'(cmd_ready), 1);
        check_eq("rmo_done", 32'(done), 0);
        drive_log.delete();
        repeat (10) @(negedge clk);
        check_eq("rmo_no_drive", drive_log.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
